// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C master arbiter: FSM state encoding and transfer direction codes.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_rr_picker.sv
// Round-robin priority encoder: first valid requester at or above rr_ptr, wrapping.
// Purely combinational, zero latency; no backpressure.
module i2c_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner,
  output logic [N_REQ-1:0] onehot
);

  int idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!valid && req_valid[idx]) begin
        valid       = 1'b1;
        winner      = IDX_W'(idx);
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_device_master between N_REQ requesters, one transaction per grant.
// Issue latency req_valid->m_enable is 2 cycles; requests wait in IDLE while the master reports not ready.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_rw,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_grant,
  output logic [N_REQ-1:0]         req_done,
  output logic [N_REQ-1:0]         req_err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic                     m_enable,
  output logic                     m_rw,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic                     m_ready
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [N_REQ-1:0] grant_q;
  logic [TO_W-1:0]  to_cnt;
  logic             result_err;
  logic             timed_out;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_oh;

  i2c_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .valid     (pick_vld),
    .winner    (pick_idx),
    .onehot    (pick_oh)
  );

  // Counter reads TIMEOUT-1 in the last wait cycle, so RESP lands exactly TIMEOUT cycles after WAIT_BUSY entry.
  assign timed_out = (to_cnt >= TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_enable  = 1'b0;
    busy      = (state != IDLE);
    req_grant = '0;
    req_done  = '0;
    req_err   = '0;
    unique case (state)
      IDLE:      if (|req_valid && m_ready) state_nxt = ARB;
      ARB: begin
        req_grant = pick_oh;
        state_nxt = pick_vld ? START : IDLE;
      end
      START: begin
        req_grant = grant_q;
        m_enable  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        req_grant = grant_q;
        if (timed_out)     state_nxt = RESP;
        else if (!m_ready) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        req_grant = grant_q;
        if (m_ready || timed_out) state_nxt = RESP;
      end
      RESP: begin
        req_grant = grant_q;
        req_done  = result_err ? '0 : grant_q;
        req_err   = result_err ? grant_q : '0;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      grant_q    <= '0;
      m_rw       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      rdata      <= '0;
      to_cnt     <= '0;
      result_err <= 1'b0;
    end else begin
      unique case (state)
        ARB: begin
          if (pick_vld) begin
            grant_q <= pick_oh;
            rr_ptr  <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            m_rw    <= req_rw[pick_idx];
            m_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            m_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
          end
        end
        START: begin
          to_cnt     <= '0;
          result_err <= 1'b0;
        end
        WAIT_BUSY: begin
          to_cnt <= to_cnt + 1'b1;
          if (timed_out) result_err <= 1'b1;
        end
        WAIT_DONE: begin
          to_cnt <= to_cnt + 1'b1;
          // Completion seen in the same cycle as the timeout still counts as success.
          if (m_ready) begin
            if (m_rw == RW_READ) rdata <= m_rdata;
          end else if (timed_out) begin
            result_err <= 1'b1;
          end
        end
        RESP:    grant_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: directed scenarios plus randomized traffic against a behavioural
// round-robin/transaction model and a simple i2c_device_master ready/busy model.
module tb_i2c_master_arbiter;

  localparam int N   = 4;
  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int TMO = 100;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_rw = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_grant, req_done, req_err;
  logic [DW-1:0]   rdata;
  logic            busy, m_enable, m_rw;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata = '0;
  logic            m_ready = 1'b1;

  i2c_master_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
    .rdata(rdata), .busy(busy), .m_enable(m_enable), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Master model: after an enable, ready stays low for mdl_busy_len cycles, then returns with read data.
  int            mdl_busy_len = 20;
  int            mdl_busy_left = 0;
  bit            mdl_hang = 0;
  bit            mdl_hold = 0;
  bit            mdl_abort = 0;
  logic [DW-1:0] mdl_rdata = '0;

  always @(negedge clk) begin
    if (mdl_abort) mdl_busy_left = 0;
    if (mdl_busy_left > 0) begin
      mdl_busy_left--;
      if (mdl_busy_left == 0) m_rdata = mdl_rdata;
    end else if (m_enable === 1'b1 && !mdl_hang) begin
      mdl_busy_left = mdl_busy_len;
    end
    m_ready = !(mdl_busy_left > 0 || mdl_hold);
  end

  // Reference state
  int            ref_ptr = 0;
  logic [DW-1:0] exp_rdata = '0;

  // Observations from the last transaction
  bit            obs_tmo;
  int            obs_win, obs_lat, obs_resp, obs_extra_en;
  logic [N-1:0]  obs_grant, obs_done, obs_err, obs_grant_after;
  logic [AW-1:0] obs_addr, obs_addr_resp;
  logic [DW-1:0] obs_wdata, obs_wdata_resp, obs_rdata;
  logic          obs_rw, obs_busy_after;

  function automatic int oh2idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i] === 1'b1) r = (r == -1) ? i : -2;
    return (r < 0) ? -1 : r;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int ref_pick(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rw[i]             = rw;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i]          = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ref_ptr = 0;
    exp_rdata = '0;
    @(negedge clk);
  endtask

  task automatic run_txn(input bit scramble);
    int cyc = 0;
    obs_tmo = 0; obs_win = -1; obs_extra_en = 0; obs_done = '0; obs_err = '0;
    while (m_enable !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    obs_lat = cyc;
    if (m_enable !== 1'b1) begin obs_tmo = 1; return; end
    obs_grant = req_grant; obs_win = oh2idx(req_grant);
    obs_addr = m_addr; obs_wdata = m_wdata; obs_rw = m_rw;
    if (scramble && obs_win >= 0) begin
      req_addr[obs_win*AW +: AW]  = AW'($urandom);
      req_wdata[obs_win*DW +: DW] = $urandom;
      req_rw[obs_win]             = ~req_rw[obs_win];
    end
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (m_enable === 1'b1) obs_extra_en++;
    end while (req_done == '0 && req_err == '0 && cyc < TMO + 50);
    obs_resp = cyc; obs_done = req_done; obs_err = req_err; obs_rdata = rdata;
    obs_addr_resp = m_addr; obs_wdata_resp = m_wdata;
    if (req_done == '0 && req_err == '0) obs_tmo = 1;
    @(negedge clk);
    obs_busy_after = busy; obs_grant_after = req_grant;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if ({req_grant, req_done, req_err} !== '0) begin n_errors++; $display("FAIL reset_req_out: got %h want 0", {req_grant, req_done, req_err}); end
    n_checks++; if ({m_enable, m_rw, m_addr, m_wdata, rdata} !== '0) begin n_errors++; $display("FAIL reset_m_out: got %h want 0", {m_enable, m_rw, m_addr, m_wdata, rdata}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    mdl_busy_len = 20;
    set_req(0, 1'b0, 7'h50, 32'hAABCCC0F);
    run_txn(0);
    req_valid[0] = 1'b0;
    n_checks++; if (obs_tmo !== 1'b0) begin n_errors++; $display("FAIL wr_bound: transaction did not complete"); end
    n_checks++; if (obs_lat !== 2) begin n_errors++; $display("FAIL wr_latency: got %0d want 2", obs_lat); end
    n_checks++; if (obs_addr !== 7'h50 || obs_wdata !== 32'hAABCCC0F || obs_rw !== 1'b0) begin n_errors++; $display("FAIL wr_cmd: got %h/%h/%b want 50/aabccc0f/0", obs_addr, obs_wdata, obs_rw); end
    n_checks++; if (obs_extra_en !== 0) begin n_errors++; $display("FAIL wr_enable_pulse: got %0d extra enables want 0", obs_extra_en); end
    n_checks++; if (obs_done !== 4'b0001 || obs_err !== 4'b0000) begin n_errors++; $display("FAIL wr_resp: got done=%b err=%b want 0001/0000", obs_done, obs_err); end
    n_checks++; if (obs_resp !== 21) begin n_errors++; $display("FAIL wr_resp_time: got %0d want 21", obs_resp); end
    n_checks++; if (obs_busy_after !== 1'b0 || obs_grant_after !== '0) begin n_errors++; $display("FAIL wr_after: got busy=%b grant=%b want 0/0000", obs_busy_after, obs_grant_after); end
    ref_ptr = 1;
  endtask

  task automatic test_single_read();
    mdl_busy_len = 8;
    mdl_rdata = 32'h12345678;
    set_req(2, 1'b1, 7'h3C, 32'h0);
    run_txn(0);
    req_valid[2] = 1'b0;
    exp_rdata = 32'h12345678;
    n_checks++; if (obs_win !== 2 || obs_addr !== 7'h3C || obs_rw !== 1'b1) begin n_errors++; $display("FAIL rd_cmd: got win=%0d addr=%h rw=%b want 2/3c/1", obs_win, obs_addr, obs_rw); end
    n_checks++; if (obs_done !== 4'b0100 || obs_err !== 4'b0000) begin n_errors++; $display("FAIL rd_resp: got done=%b err=%b want 0100/0000", obs_done, obs_err); end
    n_checks++; if (obs_rdata !== 32'h12345678) begin n_errors++; $display("FAIL rd_data: got %h want 12345678", obs_rdata); end
    ref_ptr = 3;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    mdl_busy_len = 3;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(7'h10 + i), 32'hC0DE0000 + i);
    for (int k = 0; k < 5; k++) begin
      run_txn(0);
      n_checks++; if (obs_win !== exp_order[k] || obs_done !== onehot(exp_order[k])) begin n_errors++; $display("FAIL rr_order[%0d]: got win=%0d done=%b want %0d", k, obs_win, obs_done, exp_order[k]); end
    end
    req_valid = '0;
    set_req(1, 1'b0, 7'h21, 32'h1);
    run_txn(0);
    req_valid = '0;
    n_checks++; if (obs_win !== 1) begin n_errors++; $display("FAIL rr_single1: got %0d want 1", obs_win); end
    set_req(1, 1'b0, 7'h21, 32'h1);
    set_req(3, 1'b0, 7'h23, 32'h3);
    run_txn(0);
    req_valid[3] = 1'b0;
    n_checks++; if (obs_win !== 3) begin n_errors++; $display("FAIL rr_ptr2_pick: got %0d want 3", obs_win); end
    run_txn(0);
    req_valid = '0;
    n_checks++; if (obs_win !== 1) begin n_errors++; $display("FAIL rr_wrap_pick: got %0d want 1", obs_win); end
    ref_ptr = 2;
  endtask

  task automatic test_timeout();
    mdl_busy_len = 5;
    mdl_rdata = 32'hDEADBEEF;
    set_req(2, 1'b1, 7'h11, 32'h0);
    run_txn(0);
    req_valid[2] = 1'b0;
    exp_rdata = mdl_rdata;
    n_checks++; if (obs_done !== 4'b0100 || obs_rdata !== exp_rdata) begin n_errors++; $display("FAIL to_pre_read: got done=%b rdata=%h want 0100/%h", obs_done, obs_rdata, exp_rdata); end
    mdl_hang = 1;
    set_req(3, 1'b1, 7'h12, 32'h0);
    run_txn(0);
    req_valid[3] = 1'b0;
    mdl_hang = 0;
    n_checks++; if (obs_err !== 4'b1000 || obs_done !== 4'b0000) begin n_errors++; $display("FAIL to_resp: got err=%b done=%b want 1000/0000", obs_err, obs_done); end
    n_checks++; if (obs_resp !== TMO + 1) begin n_errors++; $display("FAIL to_time: got %0d want %0d", obs_resp, TMO + 1); end
    n_checks++; if (obs_rdata !== exp_rdata) begin n_errors++; $display("FAIL to_rdata: got %h want %h", obs_rdata, exp_rdata); end
    n_checks++; if (obs_busy_after !== 1'b0) begin n_errors++; $display("FAIL to_busy_after: got %b want 0", obs_busy_after); end
    ref_ptr = 0;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    int cyc = 0;
    mdl_busy_len = 60;
    set_req(0, 1'b1, 7'h44, 32'h0);
    while (m_enable !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    n_checks++; if (m_enable !== 1'b1) begin n_errors++; $display("FAIL rm_issue: no enable within bound"); end
    repeat (4) @(negedge clk);
    mdl_hold = 1;
    rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || req_grant !== '0 || m_enable !== 1'b0) begin n_errors++; $display("FAIL rm_ctrl_zero: got busy=%b grant=%b en=%b want 0", busy, req_grant, m_enable); end
    n_checks++; if ({m_addr, m_wdata, m_rw, rdata} !== '0) begin n_errors++; $display("FAIL rm_data_zero: got %h want 0", {m_addr, m_wdata, m_rw, rdata}); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_rdata = '0;
    ref_ptr = 0;
    req_valid = '0;
    set_req(1, 1'b0, 7'h55, 32'h55AA55AA);
    repeat (10) begin
      @(negedge clk);
      if (m_enable !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rm_blocked: got %0d issuing cycles want 0", bad); end
    mdl_busy_len = 4;
    mdl_abort = 1; mdl_hold = 0;
    @(negedge clk);
    mdl_abort = 0;
    run_txn(0);
    req_valid[1] = 1'b0;
    n_checks++; if (obs_win !== 1 || obs_done !== 4'b0010 || obs_addr !== 7'h55) begin n_errors++; $display("FAIL rm_after: got win=%0d done=%b addr=%h want 1/0010/55", obs_win, obs_done, obs_addr); end
    ref_ptr = 2;
  endtask

  task automatic test_withdraw();
    int bad = 0;
    set_req(3, 1'b0, 7'h33, 32'h33);
    @(negedge clk);
    req_valid[3] = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL wd_arb_entered: got busy=%b want 1", busy); end
    repeat (6) begin
      @(negedge clk);
      if (m_enable !== 1'b0 || req_grant !== '0 || req_done !== '0 || req_err !== '0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL wd_no_grant: got %0d active cycles want 0", bad); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL wd_idle: got busy=%b want 0", busy); end
    mdl_busy_len = 3;
    set_req(1, 1'b0, 7'h31, 32'h1);
    set_req(3, 1'b0, 7'h33, 32'h3);
    run_txn(0);
    req_valid = '0;
    n_checks++; if (obs_win !== ref_pick(4'b1010, ref_ptr)) begin n_errors++; $display("FAIL wd_ptr_kept: got %0d want %0d", obs_win, ref_pick(4'b1010, ref_ptr)); end
    ref_ptr = (ref_pick(4'b1010, ref_ptr) + 1) % N;
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int            ew, el;
      bit            hang;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          erw;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom), AW'($urandom), $urandom);
      if (req_valid == '0) set_req($urandom_range(0, N - 1), 1'($urandom), AW'($urandom), $urandom);
      hang = ($urandom_range(0, 7) == 0);
      el = $urandom_range(2, 40);
      mdl_hang = hang; mdl_busy_len = el; mdl_rdata = $urandom;
      ew = ref_pick(req_valid, ref_ptr);
      ea = req_addr[ew*AW +: AW]; ed = req_wdata[ew*DW +: DW]; erw = req_rw[ew];
      run_txn(1);
      req_valid[ew] = 1'b0;
      if (obs_win >= 0) req_valid[obs_win] = 1'b0;
      mdl_hang = 0;
      if (!hang && erw) exp_rdata = mdl_rdata;
      ref_ptr = (ew + 1) % N;
      n_checks++; if (obs_tmo !== 1'b0) begin n_errors++; $display("FAIL rnd_bound[%0d]: transaction did not complete", it); end
      n_checks++; if (obs_win !== ew || obs_grant !== onehot(ew)) begin n_errors++; $display("FAIL rnd_win[%0d]: got %0d grant=%b want %0d", it, obs_win, obs_grant, ew); end
      n_checks++; if (obs_addr !== ea || obs_wdata !== ed || obs_rw !== erw) begin n_errors++; $display("FAIL rnd_cmd[%0d]: got %h/%h/%b want %h/%h/%b", it, obs_addr, obs_wdata, obs_rw, ea, ed, erw); end
      n_checks++; if (obs_addr_resp !== ea || obs_wdata_resp !== ed) begin n_errors++; $display("FAIL rnd_latched[%0d]: got %h/%h want %h/%h", it, obs_addr_resp, obs_wdata_resp, ea, ed); end
      n_checks++; if (obs_done !== (hang ? '0 : onehot(ew)) || obs_err !== (hang ? onehot(ew) : '0)) begin n_errors++; $display("FAIL rnd_resp[%0d]: got done=%b err=%b hang=%0d", it, obs_done, obs_err, hang); end
      n_checks++; if (obs_resp !== (hang ? TMO + 1 : el + 1)) begin n_errors++; $display("FAIL rnd_time[%0d]: got %0d want %0d", it, obs_resp, hang ? TMO + 1 : el + 1); end
      n_checks++; if (obs_rdata !== exp_rdata) begin n_errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", it, obs_rdata, exp_rdata); end
      n_checks++; if (obs_busy_after !== 1'b0) begin n_errors++; $display("FAIL rnd_idle[%0d]: got busy=%b want 0", it, obs_busy_after); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
